bias_seq_ctrl: RTL and testbench
================================

Name: bias_seq_ctrl

Overview:
Sequencer and bias-vector store that feeds the 32-lane saturating bias adder.
- Holds up to BIAS_DEPTH 512-bit bias vectors, one per output-channel group, loaded through a config write port.
- Steps through groups as NPE result beats arrive, pairing each beat with its group's bias vector.
- Presents each pair, registered, to the adder with valid/ready backpressure.
- Sits between the NPE result stream and the bias adder / writeback path.

Parameters:
DATA_WIDTH, 16, lane width.
LANES, 32, lanes per beat; vector width = DATA_WIDTH*LANES = 512.
BIAS_DEPTH, 16, bias vector entries; ADDR_W = clog2(BIAS_DEPTH) = 4.
BEAT_W, 16, width of the beats-per-group counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cfg_start  in  1  single-cycle pulse; sampled in IDLE only.
cfg_group_num  in  ADDR_W+1  number of groups for the job, 1..BIAS_DEPTH.
cfg_beats_per_group  in  BEAT_W  beats per group, >=1.
bias_wr_en  in  1  bias vector write strobe.
bias_wr_addr  in  ADDR_W  bias entry index.
bias_wr_data  in  512  bias vector.
npe_data  in  512  NPE result beat.
npe_data_valid  in  1  beat valid.
npe_data_ready  out  1  beat accepted when valid&&ready.
add_npe_data  out  512  registered beat to adder.
add_bias_data  out  512  registered matching bias vector to adder.
add_valid  out  1  output pair valid.
add_ready  in  1  downstream accept.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at job end.
cfg_err  out  1  one-cycle pulse on an illegal start or a write while busy.
stall_cnt  out  32  perf counter (optional feature).

Behaviour:
Reset values:
- All outputs 0; state IDLE; pointers, counters and output register cleared.
- Bias store contents are not reset.

FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on cfg_start when cfg_group_num in 1..BIAS_DEPTH and cfg_beats_per_group != 0.
  - On that transition, latch both config values and clear grp_ptr and beat_cnt.
  - cfg_start with an illegal config: cfg_err pulse, stay IDLE, no done.
- RUN:
  - npe_data_ready = !add_valid || add_ready (1-entry pipeline register with pass-through refill).
  - Each handshake loads add_npe_data <= npe_data and add_bias_data <= store[grp_ptr], sets add_valid, and increments beat_cnt.
  - When beat_cnt == beats-1 on a handshake: beat_cnt <= 0, grp_ptr++.
  - When the last beat of the last group handshakes: go to DRAIN.
- DRAIN:
  - npe_data_ready = 0.
  - When add_valid==0, or the add_valid&&add_ready handshake occurs: go to IDLE and pulse done in the cycle the state returns to IDLE.
- In IDLE, npe_data_ready = 0; beats presented in IDLE are not consumed.

Output register:
- add_valid clears on add_ready when there is no new handshake the same cycle.
- Simultaneous output drain and input accept keeps add_valid = 1 with the new data.
- Latency is 1 cycle from input handshake to add_valid.
- add_* data holds stable while add_valid && !add_ready.

Bias writes:
- Accepted in IDLE only; the write occurs on that clock edge.
- bias_wr_en while busy: write dropped, cfg_err pulses.
- A write and cfg_start in the same IDLE cycle: the write lands first, and the job sees the new value.

Boundary cases:
- grp_ptr never wraps within a job.
- beats_per_group = 1 advances the group every beat.
- Asynchronous reset mid-job returns to IDLE immediately and discards the in-flight beat; there is no done pulse.

Optional Feature:
BIAS_SEQ_PERF_CNT_EN
- With the macro defined: stall_cnt counts RUN cycles with npe_data_valid && !npe_data_ready, saturates at 2^32-1, and clears on an accepted cfg_start and on reset.
- Without the macro: stall_cnt is tied to 0 and no counter logic is present.

Decomposition:
Shared package holds:
- DATA_WIDTH, LANES, VEC_W = 512, BIAS_DEPTH, ADDR_W.
- The state enum (IDLE/RUN/DRAIN).
- The cfg record typedef (group_num, beats_per_group).

One sub-module, bias_vec_store: BIAS_DEPTH x 512 register file with one synchronous write port and one combinational read port indexed by grp_ptr. The FSM, counters and output register stay in bias_seq_ctrl.

Test Plan:
1. Basic run: write store[0]=all 0x0001, store[1]=all 0x0002; start with groups=2, beats=3; stream 6 beats with add_ready=1. Beats 0-2 pair with 0x0001 and beats 3-5 with 0x0002, 1-cycle latency, done pulses once after the 6th output.
2. Backpressure: same job with add_ready held low 4 cycles after the first output. npe_data_ready drops, add_* holds stable, no beat is lost or duplicated, and the order is preserved.
3. Illegal configs: cfg_start with groups=0, then groups=17, then beats=0. cfg_err pulses each time, busy stays 0, no done.
4. Write while busy: bias_wr_en to addr 1 during RUN. cfg_err pulses and store[1] is unchanged on the next job's group-1 beats.
5. Reset mid-job: assert rst_n low after 2 of 6 beats. All outputs are 0 at once, state is IDLE, and a fresh job afterward runs normally with the prior bias contents intact.
6. With BIAS_SEQ_PERF_CNT_EN: hold add_ready low for 5 cycles while npe_data_valid=1. stall_cnt reads 5, and it clears on the next accepted cfg_start.

Source files
------------

// File: rtl/bias_seq_ctrl_pkg.sv
// Shared definitions for the bias sequencer: vector geometry, store depth,
// the controller state encoding and the per-job configuration record.
package bias_seq_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned LANES      = 32;
    localparam int unsigned VEC_W      = DATA_WIDTH * LANES;
    localparam int unsigned BIAS_DEPTH = 16;
    localparam int unsigned ADDR_W     = $clog2(BIAS_DEPTH);
    localparam int unsigned BEAT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W:0]   group_num;
        logic [BEAT_W-1:0] beats_per_group;
    } cfg_t;

    // A job needs 1..BIAS_DEPTH groups and at least one beat per group.
    function automatic logic cfg_legal(input logic [ADDR_W:0]   group_num,
                                       input logic [BEAT_W-1:0] beats_per_group);
        return (group_num != '0) &&
               (group_num <= (ADDR_W+1)'(BIAS_DEPTH)) &&
               (beats_per_group != '0);
    endfunction

endpackage

// File: rtl/bias_seq_ctrl_store.sv
// Bias vector register file: one synchronous write port, one combinational
// read port. Contents are deliberately left out of reset.
module bias_vec_store
    import bias_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [VEC_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [VEC_W-1:0]  rd_data
);

    logic [VEC_W-1:0] mem_q [BIAS_DEPTH];

    // Write the addressed entry on the clock edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bias_seq_ctrl.sv
// Bias sequencer: pairs each NPE result beat with its group's bias vector and
// presents the pair, registered, to the saturating bias adder.
// Optional stall performance counter enabled by BIAS_SEQ_PERF_CNT_EN.
module bias_seq_ctrl
    import bias_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [ADDR_W:0]   cfg_group_num,
    input  logic [BEAT_W-1:0] cfg_beats_per_group,
    input  logic              bias_wr_en,
    input  logic [ADDR_W-1:0] bias_wr_addr,
    input  logic [VEC_W-1:0]  bias_wr_data,
    input  logic [VEC_W-1:0]  npe_data,
    input  logic              npe_data_valid,
    output logic              npe_data_ready,
    output logic [VEC_W-1:0]  add_npe_data,
    output logic [VEC_W-1:0]  add_bias_data,
    output logic              add_valid,
    input  logic              add_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [31:0]       stall_cnt
);

    state_e            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic [ADDR_W-1:0] grp_ptr_q, grp_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              add_valid_q, add_valid_d;
    logic [VEC_W-1:0]  add_npe_q, add_npe_d;
    logic [VEC_W-1:0]  add_bias_q, add_bias_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              start_ok;
    logic              in_hs;
    logic              last_beat;
    logic              last_grp;
    logic              store_wr_en;
    logic [VEC_W-1:0]  store_rd_data;

    assign start_ok    = (state_q == IDLE) && cfg_start &&
                         cfg_legal(cfg_group_num, cfg_beats_per_group);
    assign store_wr_en = bias_wr_en && (state_q == IDLE);

    // The output register refills in the same cycle it drains.
    assign npe_data_ready = (state_q == RUN) && (!add_valid_q || add_ready);
    assign in_hs          = npe_data_valid && npe_data_ready;

    assign last_beat = (beat_cnt_q == cfg_q.beats_per_group - BEAT_W'(1));
    assign last_grp  = ({1'b0, grp_ptr_q} == cfg_q.group_num - (ADDR_W+1)'(1));

    bias_vec_store u_store (
        .clk     (clk),
        .wr_en   (store_wr_en),
        .wr_addr (bias_wr_addr),
        .wr_data (bias_wr_data),
        .rd_addr (grp_ptr_q),
        .rd_data (store_rd_data)
    );

    // Next-state logic for the sequencer FSM, counters and output register.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        grp_ptr_d   = grp_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        add_valid_d = add_valid_q;
        add_npe_d   = add_npe_q;
        add_bias_d  = add_bias_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        if (in_hs) begin
            add_npe_d   = npe_data;
            add_bias_d  = store_rd_data;
            add_valid_d = 1'b1;
        end else if (add_ready) begin
            add_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (start_ok) begin
                        cfg_d.group_num       = cfg_group_num;
                        cfg_d.beats_per_group = cfg_beats_per_group;
                        grp_ptr_d             = '0;
                        beat_cnt_d            = '0;
                        state_d               = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (in_hs) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        if (last_grp) begin
                            state_d = DRAIN;
                        end else begin
                            grp_ptr_d = grp_ptr_q + ADDR_W'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
                if (bias_wr_en) begin
                    cfg_err_d = 1'b1;
                end
            end
            DRAIN: begin
                if (!add_valid_q || add_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                if (bias_wr_en) begin
                    cfg_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            grp_ptr_q   <= '0;
            beat_cnt_q  <= '0;
            add_valid_q <= 1'b0;
            add_npe_q   <= '0;
            add_bias_q  <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            grp_ptr_q   <= grp_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            add_valid_q <= add_valid_d;
            add_npe_q   <= add_npe_d;
            add_bias_q  <= add_bias_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign add_npe_data  = add_npe_q;
    assign add_bias_data = add_bias_q;
    assign add_valid     = add_valid_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;

`ifdef BIAS_SEQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count RUN cycles where a beat is offered but cannot be taken; saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_ok) begin
            stall_cnt_d = '0;
        end else if ((state_q == RUN) && npe_data_valid && !npe_data_ready &&
                     (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Self-checking bench for bias_seq_ctrl: a job-level model (accepted-beat
// queue, beat index -> group mapping) checked every cycle, plus literal
// expectations for the directed scenarios.
module tb_bias_seq_ctrl;
    import bias_seq_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_start;
    logic [ADDR_W:0]   cfg_group_num;
    logic [BEAT_W-1:0] cfg_beats_per_group;
    logic              bias_wr_en;
    logic [ADDR_W-1:0] bias_wr_addr;
    logic [VEC_W-1:0]  bias_wr_data;
    logic [VEC_W-1:0]  npe_data;
    logic              npe_data_valid;
    logic              npe_data_ready;
    logic [VEC_W-1:0]  add_npe_data;
    logic [VEC_W-1:0]  add_bias_data;
    logic              add_valid;
    logic              add_ready;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [31:0]       stall_cnt;

    bias_seq_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_start           (cfg_start),
        .cfg_group_num       (cfg_group_num),
        .cfg_beats_per_group (cfg_beats_per_group),
        .bias_wr_en          (bias_wr_en),
        .bias_wr_addr        (bias_wr_addr),
        .bias_wr_data        (bias_wr_data),
        .npe_data            (npe_data),
        .npe_data_valid      (npe_data_valid),
        .npe_data_ready      (npe_data_ready),
        .add_npe_data        (add_npe_data),
        .add_bias_data       (add_bias_data),
        .add_valid           (add_valid),
        .add_ready           (add_ready),
        .busy                (busy),
        .done                (done),
        .cfg_err             (cfg_err),
        .stall_cnt           (stall_cnt)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h (low 64 bits)", nm, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [511:0] mkvec(input logic [15:0] v);
        return {32{v}};
    endfunction

    // ---------------- job-level model ----------------
    typedef struct {
        logic [511:0] n;
        logic [511:0] b;
    } pair_t;

    pair_t        mq[$];
    logic [511:0] mstore [16];
    int           phase;        // 0 idle, 1 accepting beats, 2 draining
    int           mcnt, mtotal, mbeats;
    logic [31:0]  mstall;
    logic         exp_done, exp_err;
    // events seen in the previous cycle, applied at the following edge
    logic         p_wr, p_hs_in, p_hs_out, p_exit, p_start, p_err, p_stall;
    logic [3:0]   p_addr;
    logic [511:0] p_wdata;
    pair_t        p_pair;
    int           p_g, p_b;

    // observation logs for the literal checks
    logic [15:0]  log_npe[$];
    logic [15:0]  log_bias[$];
    int           done_cnt = 0;
    int           err_cnt  = 0;

    initial begin
        phase = 0; mcnt = 0; mtotal = 0; mbeats = 1; mstall = '0;
        p_wr = 0; p_hs_in = 0; p_hs_out = 0; p_exit = 0; p_start = 0;
        p_err = 0; p_stall = 0; p_g = 0; p_b = 1; p_addr = '0; p_wdata = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            phase = 0; mcnt = 0; mstall = '0;
            p_wr = 0; p_hs_in = 0; p_hs_out = 0; p_exit = 0; p_start = 0;
            p_err = 0; p_stall = 0;
            chk("rst_add_valid", 512'(add_valid), '0);
            chk("rst_busy", 512'(busy), '0);
            chk("rst_done", 512'(done), '0);
            chk("rst_cfg_err", 512'(cfg_err), '0);
            chk("rst_ready", 512'(npe_data_ready), '0);
            chk("rst_add_npe", add_npe_data, '0);
            chk("rst_add_bias", add_bias_data, '0);
            chk("rst_stall_cnt", 512'(stall_cnt), '0);
        end else begin
            logic exp_ready;
            logic legal;
            // apply last cycle's events as of the clock edge just passed
            if (p_wr) mstore[p_addr] = p_wdata;
            if (p_hs_out) void'(mq.pop_front());
            if (p_hs_in) begin
                mq.push_back(p_pair);
                mcnt++;
                if (mcnt == mtotal) phase = 2;
            end
            exp_done = p_exit;
            if (p_exit) phase = 0;
            if (p_start) begin
                phase = 1; mcnt = 0; mbeats = p_b; mtotal = p_g * p_b; mstall = '0;
            end
            exp_err = p_err;
            if (p_stall && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;

            // compare
            chk("add_valid", 512'(add_valid), 512'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("add_npe_data", add_npe_data, mq[0].n);
                chk("add_bias_data", add_bias_data, mq[0].b);
            end
            exp_ready = (phase == 1) && (mq.size() == 0 || add_ready);
            chk("npe_data_ready", 512'(npe_data_ready), 512'(exp_ready));
            chk("busy", 512'(busy), 512'(phase != 0));
            chk("done", 512'(done), 512'(exp_done));
            chk("cfg_err", 512'(cfg_err), 512'(exp_err));
`ifdef BIAS_SEQ_PERF_CNT_EN
            chk("stall_cnt", 512'(stall_cnt), 512'(mstall));
`else
            chk("stall_cnt", 512'(stall_cnt), '0);
`endif
            if (done) done_cnt++;
            if (cfg_err) err_cnt++;
            if (add_valid && add_ready) begin
                log_npe.push_back(add_npe_data[15:0]);
                log_bias.push_back(add_bias_data[15:0]);
            end

            // record this cycle's events
            legal    = (cfg_group_num >= 1) && (cfg_group_num <= 16) && (cfg_beats_per_group != 0);
            p_hs_in  = npe_data_valid && exp_ready;
            if (p_hs_in) begin
                p_pair.n = npe_data;
                p_pair.b = mstore[mcnt / mbeats];
            end
            p_hs_out = (mq.size() != 0) && add_ready;
            p_exit   = (phase == 2) && (mq.size() == 0 || add_ready);
            p_wr     = bias_wr_en && (phase == 0);
            p_addr   = bias_wr_addr;
            p_wdata  = bias_wr_data;
            p_start  = cfg_start && (phase == 0) && legal;
            p_g      = int'(cfg_group_num);
            p_b      = int'(cfg_beats_per_group);
            p_err    = (cfg_start && (phase == 0) && !legal) || (bias_wr_en && (phase != 0));
            p_stall  = (phase == 1) && npe_data_valid && !exp_ready;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bias(input int addr, input logic [15:0] v);
        bias_wr_en   = 1'b1;
        bias_wr_addr = 4'(addr);
        bias_wr_data = mkvec(v);
        step();
        bias_wr_en   = 1'b0;
    endtask

    task automatic start_job(input int g, input int b);
        cfg_start           = 1'b1;
        cfg_group_num       = 5'(g);
        cfg_beats_per_group = 16'(b);
        step();
        cfg_start           = 1'b0;
    endtask

    // Offer n beats; after the first output appears, hold add_ready low 'hold' cycles.
    task automatic send_beats(input int n, input int base, input int hold);
        int idx = 0;
        int budget = 0;
        int held = 0;
        bit started = 0;
        npe_data_valid = 1'b1;
        while (idx < n && budget < 200) begin
            npe_data = mkvec(16'(base + idx));
            if (started && held < hold) begin
                add_ready = 1'b0;
                held++;
            end else begin
                add_ready = 1'b1;
            end
            @(negedge clk);
            if (add_valid) started = 1;
            if (npe_data_ready) idx++;
            step();
            budget++;
        end
        npe_data_valid = 1'b0;
        add_ready      = 1'b1;
        checks++;
        if (idx < n) begin
            errs++;
            $display("FAIL send_timeout sent=%0d want=%0d", idx, n);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        checks++;
        if (busy) begin
            errs++;
            $display("FAIL idle_timeout busy=%0b after %0d cycles", busy, n);
        end
        step();
    endtask

    task automatic clear_logs();
        log_npe.delete();
        log_bias.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Expect n outputs: npe lane = base+k, bias lane = group value (g0 / g1 by beat index).
    task automatic check_log(input string nm, input int n, input int base, input int bpg,
                             input logic [15:0] g0, input logic [15:0] g1);
        chk({nm, "_count"}, 512'(log_npe.size()), 512'(n));
        for (int k = 0; k < n && k < log_npe.size(); k++) begin
            chk({nm, "_npe"}, 512'(log_npe[k]), 512'(16'(base + k)));
            chk({nm, "_bias"}, 512'(log_bias[k]), 512'((k / bpg == 0) ? g0 : g1));
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_group_num = '0; cfg_beats_per_group = '0;
        bias_wr_en = 1'b0; bias_wr_addr = '0; bias_wr_data = '0;
        npe_data = '0; npe_data_valid = 1'b0; add_ready = 1'b1;
        #3;
        chk("reset_valid", 512'(add_valid), '0);
        chk("reset_busy", 512'(busy), '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // 1: basic two-group run
        write_bias(0, 16'h0001);
        write_bias(1, 16'h0002);
        clear_logs();
        start_job(2, 3);
        send_beats(6, 16'h0100, 0);
        wait_idle();
        check_log("basic", 6, 16'h0100, 3, 16'h0001, 16'h0002);
        chk("basic_done_cnt", 512'(done_cnt), 512'(1));

        // 2: backpressure for 4 cycles after the first output
        clear_logs();
        start_job(2, 3);
        send_beats(6, 16'h0200, 4);
        wait_idle();
        check_log("bp", 6, 16'h0200, 3, 16'h0001, 16'h0002);
        chk("bp_done_cnt", 512'(done_cnt), 512'(1));

        // 3: illegal configurations
        clear_logs();
        start_job(0, 3);  step();
        chk("ill_g0_busy", 512'(busy), '0);
        start_job(17, 3); step();
        chk("ill_g17_busy", 512'(busy), '0);
        start_job(2, 0);  step();
        chk("ill_b0_busy", 512'(busy), '0);
        chk("ill_err_cnt", 512'(err_cnt), 512'(3));
        chk("ill_done_cnt", 512'(done_cnt), '0);

        // 4: bias write while busy is dropped
        clear_logs();
        start_job(2, 2);
        write_bias(1, 16'hDEAD);
        send_beats(4, 16'h0300, 0);
        wait_idle();
        chk("wrbusy_err_cnt", 512'(err_cnt), 512'(1));
        check_log("wrbusy", 4, 16'h0300, 2, 16'h0001, 16'h0002);
        clear_logs();
        start_job(2, 1);
        send_beats(2, 16'h0380, 0);
        wait_idle();
        check_log("wrbusy_next", 2, 16'h0380, 1, 16'h0001, 16'h0002);

        // 5: reset mid-job
        clear_logs();
        start_job(2, 3);
        send_beats(2, 16'h0400, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 512'(add_valid), '0);
        chk("midrst_busy", 512'(busy), '0);
        chk("midrst_ready", 512'(npe_data_ready), '0);
        chk("midrst_npe", add_npe_data, '0);
        chk("midrst_bias", add_bias_data, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("midrst_done_cnt", 512'(done_cnt), '0);
        clear_logs();
        start_job(2, 3);
        send_beats(6, 16'h0500, 0);
        wait_idle();
        check_log("postrst", 6, 16'h0500, 3, 16'h0001, 16'h0002);
        chk("postrst_done_cnt", 512'(done_cnt), 512'(1));

`ifdef BIAS_SEQ_PERF_CNT_EN
        // 6: stall counter
        clear_logs();
        start_job(1, 8);
        send_beats(8, 16'h0600, 5);
        wait_idle();
        chk("perf_stall_5", 512'(stall_cnt), 512'(5));
        start_job(1, 1);
        chk("perf_clear", 512'(stall_cnt), '0);
        send_beats(1, 16'h0700, 0);
        wait_idle();
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
